// File: rtl/mac_matmul_sequencer.sv
// Matrix-multiply sequencer: walks every C(i,j) of C = A x B, streams A row / B column
// reads from synchronous BRAMs through one MAC and writes each 48-bit sum into C_flat.
module mac_matmul_sequencer #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 48,
    parameter int RD_LAT = 1,
    localparam int ADDR_W = $clog2(N * N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       a_addr,
    output logic [ADDR_W-1:0]       b_addr,
    input  logic [DATA_W-1:0]       a_dout,
    input  logic [DATA_W-1:0]       b_dout,
    output logic [ACC_W*N*N-1:0]    C_flat,
    output logic [2:0]              state_dbg
);

    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int WAIT_W = 3;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state, state_d;
    logic [IDX_W-1:0]    i_q, j_q, k_q;
    logic [IDX_W-1:0]    i_d, j_d, k_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                issue;
    logic                store_en;
    logic [RD_LAT-1:0]   v_pipe;
    logic [RD_LAT-1:0]   f_pipe;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    c_q [N*N];
    logic [ADDR_W-1:0]   c_idx;
    logic [PROD_W-1:0]   a_ext, b_ext, prod;
    logic [ACC_W-1:0]    prod_ext;

    // Handshake: start is a one-cycle request honoured only in IDLE; there is no
    // back-pressure, so once accepted the run always completes unless reset.

    always_comb begin
        state_d  = state;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        wait_d   = wait_q;
        issue    = 1'b0;
        store_en = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            FETCH: begin
                issue = 1'b1;
                if (k_q == IDX_W'(N - 1)) begin
                    k_d     = '0;
                    wait_d  = WAIT_W'(RD_LAT);
                    state_d = WAIT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            WAIT: begin
                // The final accumulate lands on the last WAIT cycle.
                if (wait_q <= WAIT_W'(1)) begin
                    state_d = STORE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            STORE: begin
                store_en = 1'b1;
                if (j_q == IDX_W'(N - 1)) begin
                    j_d = '0;
                    if (i_q == IDX_W'(N - 1)) begin
                        i_d     = '0;
                        state_d = DONE;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = FETCH;
                    end
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            wait_q <= '0;
        end else begin
            state  <= state_d;
            i_q    <= i_d;
            j_q    <= j_d;
            k_q    <= k_d;
            wait_q <= wait_d;
        end
    end

    assign busy      = (state == FETCH) || (state == WAIT) || (state == STORE);
    assign done      = (state == DONE);
    assign rd_en     = issue;
    assign state_dbg = state;
    assign a_addr    = issue ? (ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(k_q)) : '0;
    assign b_addr    = issue ? (ADDR_W'(k_q) * ADDR_W'(N) + ADDR_W'(j_q)) : '0;
    assign c_idx     = ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(j_j_sel());

    function automatic logic [IDX_W-1:0] j_j_sel();
        return j_q;
    endfunction

    // Full signed product: operands sign-extended to the product width first.
    assign a_ext    = {{DATA_W{a_dout[DATA_W-1]}}, a_dout};
    assign b_ext    = {{DATA_W{b_dout[DATA_W-1]}}, b_dout};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // Tags travel alongside the BRAM latency so the MAC knows which returns are live.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_pipe <= '0;
            f_pipe <= '0;
        end else begin
            v_pipe[0] <= issue;
            f_pipe[0] <= issue && (k_q == '0);
            for (int p = 1; p < RD_LAT; p++) begin
                v_pipe[p] <= v_pipe[p-1];
                f_pipe[p] <= f_pipe[p-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (v_pipe[RD_LAT-1]) begin
            acc_q <= (f_pipe[RD_LAT-1] ? '0 : acc_q) + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < N * N; e++) begin
                c_q[e] <= '0;
            end
        end else if (store_en) begin
            c_q[c_idx] <= acc_q;
        end
    end

    for (genvar e = 0; e < N * N; e++) begin : g_pack
        assign C_flat[e*ACC_W +: ACC_W] = c_q[e];
    end

endmodule

// File: doc/mac_matmul_sequencer.md
Name: mac_matmul_sequencer

Overview:
- Sequencer for the MAC-based matrix-multiply path.
- On a start pulse it walks all output elements of C = A x B (N x N). For each element it issues row/column reads to the A and B BRAMs and steers the returned operands through one internal multiply-accumulate unit.
- Each finished 48-bit sum is written into the packed C_flat result bus, then done is pulsed.
- Sits between the BRAM pair and the top-level result/done outputs.

Parameters:
- N, 4: matrix dimension (square, N x N).
- DATA_W, 16: A/B element width, signed two's complement.
- ACC_W, 48: accumulator and C element width.
- RD_LAT, 1: BRAM read latency in cycles; legal range 1..4.
- Derived localparam ADDR_W = clog2(N*N).

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle run request.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when all of C_flat is valid.
- rd_en  out  1  read enable to both BRAMs.
- a_addr  out  ADDR_W  A BRAM address, row-major.
- b_addr  out  ADDR_W  B BRAM address, row-major.
- a_dout  in  DATA_W  A BRAM read data.
- b_dout  in  DATA_W  B BRAM read data.
- C_flat  out  ACC_W*N*N  results; element (i,j) at bits [(i*N+j)*ACC_W +: ACC_W].

Behaviour:
- Reset (reset low, async):
  - state=IDLE; i, j, k cleared.
  - busy=0, done=0, rd_en=0, a_addr=0, b_addr=0.
  - Accumulator, valid pipe and C_flat all zero.
  - Reset mid-run aborts immediately; nothing is retained.
- States: IDLE, FETCH, WAIT, STORE, DONE.
- IDLE:
  - start=1 at an edge -> FETCH; i=j=k=0; busy=1 from the next cycle.
  - start is ignored in every other state.
- FETCH:
  - rd_en=1, a_addr=i*N+k, b_addr=k*N+j.
  - k increments each cycle. After the k=N-1 issue -> WAIT with wait counter = RD_LAT.
- Valid pipe:
  - Each FETCH issue pushes {valid, first=(k==0)} into an RD_LAT-deep shift register.
  - When the delayed valid is high: acc <= (first ? 0 : acc) + sext(a_dout*b_dout).
  - The product is a full 2*DATA_W signed product, sign-extended to ACC_W. There is no saturation; the sum wraps modulo 2^ACC_W.
- WAIT:
  - rd_en=0; lasts exactly RD_LAT cycles, then -> STORE.
- STORE:
  - The C_flat slice (i,j) is loaded with acc at the end of this cycle.
  - Indices advance: j+1, or j=0 and i+1 when j=N-1.
  - If (i,j)=(N-1,N-1) -> DONE, else -> FETCH with k=0.
- DONE:
  - done=1 for exactly one cycle; busy=0 in this cycle; -> IDLE.
- Timing:
  - Per element: N+RD_LAT+1 cycles.
  - With start sampled at edge 0, done is high in cycle N*N*(N+RD_LAT+1)+1. Defaults give cycle 97.
- C_flat:
  - Holds its previous contents until each slice is overwritten.
  - Never cleared by start, only by reset.
  - Slices update in row-major order during a run.
- BRAM contract: synchronous read; data for the address presented in cycle t is valid on *_dout in cycle t+RD_LAT.
- A/B BRAM contents must not change while busy=1; if they do, C_flat values are unspecified.
- No back-pressure: a run always completes unless reset.

Test Plan:
1. A = identity, B = 1..16 row-major, start at cycle 0 -> C_flat equals B sign-extended to 48 bits; done single-cycle in cycle 97; busy high cycles 1..96.
2. A and B all 0xFFFF (-1) -> every C element = 0x0000_0000_0004.
3. A and B all 0x8000 (-32768) -> every C element = 0x0001_0000_0000 (4*2^30, no overflow at ACC_W=48).
4. Build with RD_LAT=2, same data as scenario 1 -> identical C_flat; done in cycle 16*7+1 = 113; rd_en high exactly 64 cycles.
5. Pulse start again at cycle 50 -> ignored (no timing or result change). After done, load B=2*B and start -> C_flat updates slice by slice to 2*B; done again after 97 cycles.
6. Drive reset low at cycle 40 of a run -> busy, rd_en and C_flat zero within the same cycle (async). Release reset and start -> full correct result, done after 97 cycles.
